// File: rtl/temp_display_ctrl.sv
// temp_display_ctrl
//   Samples a 10-bit binary temperature on a free-running refresh tick or on an
//   update_now request. It converts the sample to BCD with a serial
//   shift-add-3 (double-dabble) engine and drives three active-low 7-segment
//   digits (bit 0..6 = segments a..g). Values above MAX_TEMP show three dashes
//   and raise overrange.
//
//   Build option: define TEMP_DISP_LZB_EN to blank leading zeros on hex100 and
//   hex10. hex1 and the overrange dashes are never blanked.

module temp_display_ctrl #(
  parameter int unsigned REFRESH_CYCLES = 50_000_000,
  parameter int unsigned TEMP_W         = 10,
  parameter int unsigned MAX_TEMP       = 999
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [TEMP_W-1:0] temp_in,
  input  logic              temp_valid,
  input  logic              update_now,
  input  logic              hold,
  output logic [0:6]        hex100,
  output logic [0:6]        hex10,
  output logic [0:6]        hex1,
  output logic              busy,
  output logic              overrange
);

  localparam int unsigned TMR_W = $clog2(REFRESH_CYCLES);
  localparam int unsigned SR_W  = 12 + TEMP_W;
  localparam int unsigned CNT_W = $clog2(TEMP_W + 1);

  localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(TEMP_W - 1);
  localparam logic [CNT_W-1:0]  CNT_SHORT = CNT_W'(TEMP_W - 2);
  localparam logic [TEMP_W-1:0] MAX_T     = TEMP_W'(MAX_TEMP);

  // Segment patterns, written abcdefg from MSB to LSB.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    CONVERT,
    ENCODE
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             tick;
  logic             trig;
  logic [SR_W-1:0]  shift_reg;
  logic [CNT_W-1:0] conv_cnt;
  logic             ovr_pend;
  logic [3:0]       bcd_h;
  logic [3:0]       bcd_t;
  logic [3:0]       bcd_o;
  logic [6:0]       seg_h;
  logic [6:0]       seg_t;
  logic [6:0]       seg_o;

  // One double-dabble iteration: correct each BCD nibble that would overflow
  // past 9 when doubled, then shift the whole word left by one.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] adj;
    adj = sr;
    for (int d = 0; d < 3; d++) begin
      if (adj[TEMP_W + 4*d +: 4] >= 4'd5)
        adj[TEMP_W + 4*d +: 4] = adj[TEMP_W + 4*d +: 4] + 4'd3;
    end
    return {adj[SR_W-2:0], 1'b0};
  endfunction

  // BCD digit to active-low abcdefg pattern.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign tick = (timer == TMR_LAST);

  // A request is honoured only when the sample is valid and the display is
  // not frozen; the FSM looks at it in IDLE only, so late requests are dropped.
  assign trig = (tick | update_now) & temp_valid & ~hold;

  // Finished BCD digits sit in the top 12 bits of the shift register.
  assign bcd_h = shift_reg[SR_W-1  -: 4];
  assign bcd_t = shift_reg[SR_W-5  -: 4];
  assign bcd_o = shift_reg[SR_W-9  -: 4];

  // Free-running refresh timer; keeps counting through hold and busy.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: registers are assigned with <= so every flop samples pre-edge values.
    if (!reset_n)  timer <= '0;
    else if (tick) timer <= '0;
    else           timer <= timer + TMR_W'(1);
  end

  // Map the converted digits to segment patterns, with optional blanking.
  always_comb begin
    // NOTE: outputs of a combinational block get a default first so no path
    // leaves them unassigned and a latch is never inferred.
    seg_h = seg7(bcd_h);
    seg_t = seg7(bcd_t);
    seg_o = seg7(bcd_o);
`ifdef TEMP_DISP_LZB_EN
    if (bcd_h == 4'd0) begin
      seg_h = SEG_BLANK;
      if (bcd_t == 4'd0) seg_t = SEG_BLANK;
    end
`endif
  end

  // Sequencer: capture, serial BCD conversion, then a single registered update
  // of all digits so no intermediate value is ever visible.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      shift_reg <= '0;
      conv_cnt  <= '0;
      ovr_pend  <= 1'b0;
      busy      <= 1'b0;
      overrange <= 1'b0;
      hex100    <= SEG_BLANK;
      hex10     <= SEG_BLANK;
      hex1      <= SEG_BLANK;
    end else begin
      unique case (state)
        IDLE: begin
          if (trig) begin
            state <= CAPTURE;
            busy  <= 1'b1;
          end
        end

        CAPTURE: begin
          shift_reg <= {{12{1'b0}}, temp_in};
          ovr_pend  <= (temp_in > MAX_T);
          // An overrange sample needs no digits; it waits one cycle less so
          // its dashes land 11 cycles after the trigger instead of 12.
          conv_cnt  <= (temp_in > MAX_T) ? CNT_SHORT : CNT_FULL;
          state     <= CONVERT;
        end

        CONVERT: begin
          shift_reg <= dabble_step(shift_reg);
          if (conv_cnt == '0) state <= ENCODE;
          else                conv_cnt <= conv_cnt - CNT_W'(1);
        end

        ENCODE: begin
          if (ovr_pend) begin
            hex100 <= SEG_DASH;
            hex10  <= SEG_DASH;
            hex1   <= SEG_DASH;
          end else begin
            hex100 <= seg_h;
            hex10  <= seg_t;
            hex1   <= seg_o;
          end
          overrange <= ovr_pend;
          busy      <= 1'b0;
          state     <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_temp_display_ctrl.sv
// Testbench for temp_display_ctrl: directed scenarios plus randomized samples,
// each checked against a decimal-arithmetic reference of the display.

module tb_temp_display_ctrl;

  localparam int TEMP_W  = 10;
  localparam int REFRESH = 16;

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] DASH  = 7'b1111110;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [TEMP_W-1:0] temp_in = '0;
  logic              temp_valid = 1'b0;
  logic              update_now = 1'b0;
  logic              hold = 1'b0;
  logic [0:6]        hex100;
  logic [0:6]        hex10;
  logic [0:6]        hex1;
  logic              busy;
  logic              overrange;

  logic [20:0] disp;
  logic [20:0] exp_disp;
  logic        exp_ovr;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cnt;

  assign disp = {hex100, hex10, hex1};

  temp_display_ctrl #(
    .REFRESH_CYCLES (REFRESH),
    .TEMP_W         (TEMP_W),
    .MAX_TEMP       (999)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .temp_in    (temp_in),
    .temp_valid (temp_valid),
    .update_now (update_now),
    .hold       (hold),
    .hex100     (hex100),
    .hex10      (hex10),
    .hex1       (hex1),
    .busy       (busy),
    .overrange  (overrange)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; edge number 16k (k>=1) carries a tick.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= 0;
    else          cnt <= cnt + 1;
  end

  function automatic logic [6:0] digit_seg(input int d);
    logic [6:0] tab [10];
    tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
            7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};
    return tab[d];
  endfunction

  // Expected display for a captured value, from decimal digits.
  function automatic logic [20:0] model_display(input int v);
    logic [6:0] sh, st, so;
    int h, t, o;
    if (v > 999) return {DASH, DASH, DASH};
    h  = v / 100;
    t  = (v / 10) % 10;
    o  = v % 10;
    sh = digit_seg(h);
    st = digit_seg(t);
    so = digit_seg(o);
`ifdef TEMP_DISP_LZB_EN
    if (h == 0) sh = BLANK;
    if (h == 0 && t == 0) st = BLANK;
`endif
    return {sh, st, so};
  endfunction

  task automatic kick(input int v);
    temp_in    = TEMP_W'(v);
    temp_valid = 1'b1;
    update_now = 1'b1;
  endtask

  // The next rising edge is the trigger edge. Follows the conversion edge by
  // edge, optionally injecting a second request (with a new temp_in and hold
  // raised) at cycle inject_at, then checks the final display.
  task automatic run_conv(input int v, input string name, input int inject_at, input int inject_val);
    int          lat;
    logic [20:0] new_disp;
    logic        new_ovr;
    logic        exp_busy;
    int          bad_busy_c;
    int          bad_hold_c;
    logic [20:0] bad_hold_v;
    lat        = (v > 999) ? 11 : 12;
    new_disp   = model_display(v);
    new_ovr    = (v > 999);
    bad_busy_c = -1;
    bad_hold_c = -1;
    bad_hold_v = '0;
    for (int c = 0; c <= lat; c++) begin
      @(posedge clk); #1;
      update_now = 1'b0;
      exp_busy = (c < lat);
      if (busy !== exp_busy && bad_busy_c < 0) bad_busy_c = c;
      if (c < lat && (disp !== exp_disp || overrange !== exp_ovr) && bad_hold_c < 0) begin
        bad_hold_c = c;
        bad_hold_v = disp;
      end
      if (c == inject_at) begin
        update_now = 1'b1;
        temp_in    = TEMP_W'(inject_val);
        hold       = 1'b1;
      end
    end
    temp_valid = 1'b0;
    hold       = 1'b0;
    n_tests++;
    if (bad_busy_c >= 0) begin
      n_fail++;
      $display("FAIL %s busy: wrong busy at cycle %0d after trigger, required high for %0d cycles", name, bad_busy_c, lat);
    end
    n_tests++;
    if (bad_hold_c >= 0) begin
      n_fail++;
      $display("FAIL %s early_change: disp=%h at cycle %0d, required %h until cycle %0d", name, bad_hold_v, bad_hold_c, exp_disp, lat);
    end
    n_tests++;
    if (disp !== new_disp || overrange !== new_ovr) begin
      n_fail++;
      $display("FAIL %s result (v=%0d): disp=%h ovr=%b, required disp=%h ovr=%b", name, v, disp, overrange, new_disp, new_ovr);
    end
    exp_disp = new_disp;
    exp_ovr  = new_ovr;
  endtask

  // Watches for cycles with no conversion and no display change; may pulse
  // update_now at cycle pulse_at.
  task automatic check_quiet(input int cycles, input string name, input int pulse_at);
    int          bad_c;
    logic        b_seen;
    logic [20:0] d_seen;
    bad_c  = -1;
    b_seen = 1'b0;
    d_seen = '0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      update_now = 1'b0;
      if ((busy !== 1'b0 || disp !== exp_disp || overrange !== exp_ovr) && bad_c < 0) begin
        bad_c  = i;
        b_seen = busy;
        d_seen = disp;
      end
      if (i == pulse_at) update_now = 1'b1;
    end
    n_tests++;
    if (bad_c >= 0) begin
      n_fail++;
      $display("FAIL %s: cycle %0d busy=%b disp=%h, required busy=0 disp=%h", name, bad_c, b_seen, d_seen, exp_disp);
    end
  endtask

  // Advance until the next rising edge is a refresh tick.
  task automatic wait_tick_next(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (cnt % REFRESH == REFRESH - 1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s tick_wait: no tick edge within 40 cycles, cnt=%0d", name, cnt);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (disp !== {BLANK, BLANK, BLANK}) begin
      n_fail++;
      $display("FAIL reset_hex: disp=%h, required %h", disp, {BLANK, BLANK, BLANK});
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: busy=%b, required 0", busy);
    end
    n_tests++;
    if (overrange !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_overrange: overrange=%b, required 0", overrange);
    end
    @(negedge clk);
    reset_n  = 1'b1;
    exp_disp = {BLANK, BLANK, BLANK};
    exp_ovr  = 1'b0;
    check_quiet(5, "reset_idle", -1);
  endtask

  task automatic test_basic();
    kick(273);
    run_conv(273, "basic_273", -1, 0);
  endtask

  task automatic test_overrange();
    kick(1000);
    run_conv(1000, "over_1000", -1, 0);
    kick(999);
    run_conv(999, "max_999", -1, 0);
    kick(1023);
    run_conv(1023, "over_1023", -1, 0);
  endtask

  task automatic test_leading_zero();
    kick(5);
    run_conv(5, "lzb_5", -1, 0);
    kick(40);
    run_conv(40, "lzb_40", -1, 0);
    kick(0);
    run_conv(0, "lzb_0", -1, 0);
  endtask

  task automatic test_tick_valid();
    kick(456);
    update_now = 1'b0;
    temp_valid = 1'b0;
    wait_tick_next("tick_invalid");
    check_quiet(14, "tick_invalid", -1);
    temp_valid = 1'b1;
    wait_tick_next("tick_valid");
    run_conv(456, "tick_valid", -1, 0);
  endtask

  task automatic test_hold();
    temp_in    = TEMP_W'(812);
    temp_valid = 1'b1;
    hold       = 1'b1;
    check_quiet(40, "hold_block", 20);
    hold = 1'b0;
    wait_tick_next("hold_release");
    run_conv(812, "hold_release", -1, 0);
  endtask

  task automatic test_update_during_convert();
    kick(618);
    run_conv(618, "update_in_convert", 4, 123);
    check_quiet(14, "no_second_update", -1);
  endtask

  task automatic test_random_back_to_back();
    int v;
    int bounds [6] = '{10, 100, 998, 1000, 905, 50};
    foreach (bounds[i]) begin
      kick(bounds[i]);
      run_conv(bounds[i], "boundary", -1, 0);
    end
    for (int i = 0; i < 16; i++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(990, 1023)) : int'($urandom_range(0, 1023));
      kick(v);
      run_conv(v, "random", -1, 0);
    end
  endtask

  task automatic test_reset_mid_run();
    kick(321);
    @(posedge clk); #1;
    update_now = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_busy: busy=%b, required 1", busy);
    end
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (disp !== {BLANK, BLANK, BLANK} || busy !== 1'b0 || overrange !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: disp=%h busy=%b ovr=%b, required disp=%h busy=0 ovr=0",
               disp, busy, overrange, {BLANK, BLANK, BLANK});
    end
    temp_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    exp_disp = {BLANK, BLANK, BLANK};
    exp_ovr  = 1'b0;
    check_quiet(14, "aborted_no_update", -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrange();
    test_leading_zero();
    test_tick_valid();
    test_hold();
    test_update_during_convert();
    test_random_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
